// File: rtl/param_fifo.sv
// param_fifo -- synchronous FIFO with registered read data, occupancy count,
// full/empty/almost flags and optional sticky overflow/underflow flags.
// Optional feature macro: PARAM_FIFO_ERR_EN (sticky error flags); when
// undefined, overflow/underflow are tied low and err_clr is ignored.
module param_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq,
  input  logic                     deq,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     err_clr,
  output logic [WIDTH-1:0]         data_out,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);

  // Storage is never reset; only pointers/count define what is valid.
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             rd_valid_q, rd_valid_d;

  logic             wr_acc;
  logic             rd_acc;

  // Status flags are pure decodes of the occupancy counter.
  always_comb begin
    full         = (count_q == CNT_FULL);
    empty        = (count_q == '0);
    almost_full  = (count_q >= CNT_AF);
    almost_empty = (count_q <= CNT_AE);
  end

  // Accept logic, pointer/count advance and read-data capture.
  always_comb begin
    rd_acc     = deq && !empty;
    // A full FIFO still takes a write when a read frees a slot this cycle.
    wr_acc     = enq && (!full || rd_acc);

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    rd_valid_d = rd_acc;

    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + AW'(1);
      data_out_d = mem_q[rd_ptr_q];
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control and output registers; reset wins over every request.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage write; gated by rst so a write in the reset cycle is discarded.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;

`ifdef PARAM_FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;
  logic ovf_set, udf_set;

  // Sticky error flags; a new error in the same cycle beats err_clr.
  always_comb begin
    ovf_set = enq && full && !rd_acc;
    udf_set = deq && empty;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (ovf_set) ovf_d = 1'b1;
    if (udf_set) udf_d = 1'b1;
  end

  // Error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL provide parameter DEPTH, default 8, number of entries; power of two, >=2.
REQ-003 SHALL provide parameter AF_LEVEL, default DEPTH-1, almost_full threshold (1..DEPTH).
REQ-004 SHALL provide parameter AE_LEVEL, default 1, almost_empty threshold (0..DEPTH-1).
REQ-005 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL provide port rst  input  1  reset; synchronous and active-high.
REQ-007 SHALL provide port enq  input  1  write request.
REQ-008 SHALL provide port deq  input  1  read request.
REQ-009 SHALL provide port data_in  input  WIDTH  write data, sampled when write is accepted.
REQ-010 SHALL provide port err_clr  input  1  clears sticky error flags.
REQ-011 SHALL provide port data_out  output  WIDTH  registered read data.
REQ-012 SHALL provide port rd_valid  output  1  one-cycle pulse, data_out updated this cycle.
REQ-013 SHALL provide port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 SHALL provide ports full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-015 SHALL provide ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 Write accepted = enq && (!full || read accepted same cycle); accepted word stored at wr_ptr, wr_ptr increments modulo DEPTH.
REQ-017 Read accepted = deq && !empty; mem[rd_ptr] registered to data_out, rd_ptr increments modulo DEPTH.
REQ-018 Read latency: data_out and rd_valid=1 valid on the edge ending the accept cycle; rd_valid=0 in every cycle following no accepted read.
REQ-019 data_out SHALL hold its last value when no read is accepted.
REQ-020 count: +1 on write only, -1 on read only, unchanged on both or neither; never exceeds DEPTH or wraps below 0.
REQ-021 Full with enq&&deq: both accepted, count stays DEPTH, oldest word read out, new word written into freed slot.
REQ-022 Empty with enq&&deq: read rejected, write accepted, count becomes 1; no fall-through of data_in to data_out.
REQ-023 full = (count==DEPTH); empty = (count==0); almost_full = (count>=AF_LEVEL); almost_empty = (count<=AE_LEVEL); all combinational from count.
REQ-024 Pointers SHALL be $clog2(DEPTH) bits wide and wrap naturally; storage order strictly first-in first-out across wrap.
REQ-025 Rejected requests SHALL leave mem, pointers and count unchanged.

Reset
REQ-026 rst sampled high at a rising edge SHALL set rd_ptr=0, wr_ptr=0, count=0, data_out=0, rd_valid=0, overflow=0, underflow=0; mem contents not cleared.
REQ-027 rst SHALL take priority over enq, deq and err_clr in the same cycle; reset mid-operation discards all stored words.
REQ-028 After reset release, first accepted write SHALL land at entry 0.

Configuration
REQ-029 Macro PARAM_FIFO_ERR_EN SHALL control the error-flag feature.
REQ-030 With PARAM_FIFO_ERR_EN defined: overflow sets on enq while full and no read accepted; underflow sets on deq while empty; both stay set until err_clr or rst; set takes priority over err_clr in the same cycle.
REQ-031 Without PARAM_FIFO_ERR_EN: overflow and underflow SHALL be constant 0, err_clr ignored; all other behaviour identical.

Verification (WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1)
REQ-032 Reset, then write 0x11,0x22,0x33,0x44 -> count=4, full=1, almost_full=1 from count=3; reads return 0x11..0x44 in order, each with rd_valid pulse one cycle after deq; empty=1 at end.
REQ-033 Fill to 4, enq 0x55 without deq -> write rejected, count=4; with ERR_EN overflow=1 until err_clr pulse, then 0.
REQ-034 Full, enq=1 deq=1 data_in=0x66 -> data_out=0x11, count=4; after draining, last word read = 0x66.
REQ-035 Empty, enq=1 deq=1 data_in=0x77 -> rd_valid=0, count=1, underflow=1 (ERR_EN); next deq returns 0x77.
REQ-036 Run 10 write/read pairs through pointer wrap (0xA0..0xA9) -> output order preserved, count never >4; assert rst with count=3 -> count=0, empty=1, data_out=0 next cycle.
